// File: rtl/oc8051_loader_pkg.sv
// Shared definitions for the oc8051 program-memory record loader.
// Holds the loader state encoding, the record type bytes that are
// accepted, and the error codes reported alongside rec_err.
package oc8051_loader_pkg;

  typedef enum logic [3:0] {
    S_LEN,
    S_AH,
    S_AL,
    S_TYPE,
    S_DATA,
    S_DROP,
    S_CSUM,
    S_COMMIT,
    S_EOF
  } state_e;

  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TYPE = 2'd3;

endpackage

// File: rtl/oc8051_rom_loader_if.sv
// Byte-stream input and program-memory write port of the record loader.
//   in_valid/in_data/in_ready : byte source handshake (master drives valid/data)
//   wr_en/wr_addr/wr_data     : program-memory write strobe, address, data
//   rec_done/rec_err/err_code : per-record result pulses
//   eof/busy                  : sticky end-of-file flag, parser-active flag
// master = byte source / observer, slave = loader.
interface oc8051_rom_loader_if #(
  parameter int ADDR_WID = 16
) ();

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_WID-1:0] wr_addr;
  logic [7:0]          wr_data;
  logic                rec_done;
  logic                rec_err;
  logic [1:0]          err_code;
  logic                eof;
  logic                busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, rec_done, rec_err, err_code, eof, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, rec_done, rec_err, err_code, eof, busy
  );

endinterface

// File: rtl/oc8051_loader_buf.sv
// Record data buffer: MAX_LEN x 8 register file holding the data bytes of
// the record being received, so nothing reaches program memory before the
// checksum has been verified.
//   clk        : clock
//   wr_en_i    : write wr_data_i at wr_idx_i
//   wr_idx_i   : write index
//   wr_data_i  : write data
//   rd_idx_i   : read index (combinational read)
//   rd_data_o  : buffered byte at rd_idx_i
module oc8051_loader_buf #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [7:0]       rd_data_o
);

  logic [7:0] mem_q [MAX_LEN];

  // Pure storage: contents are meaningless until written for a record.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/oc8051_rom_loader.sv
// oc8051 program-memory loader. Parses LEN, ADDR_H, ADDR_L, TYPE,
// DATA[LEN], CSUM records from a byte stream, buffers the data bytes and
// only after a good checksum writes them to program memory, one byte per
// cycle. Bad records are consumed completely and reported via rec_err.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of oc8051_rom_loader_if (byte input, write port,
//          rec_done/rec_err/err_code, eof, busy)
module oc8051_rom_loader
  import oc8051_loader_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int ADDR_WID = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  oc8051_rom_loader_if.slave        bus
);

  localparam int         IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [15:0]         addr_q, addr_d;
  logic                is_eof_q, is_eof_d;
  logic [1:0]          err_q, err_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_WID-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                rec_done_q, rec_done_d;
  logic                rec_err_q, rec_err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                eof_q, eof_d;

  logic                hs;
  logic [8:0]          len9, len_m1;
  logic [7:0]          sum_next;
  logic                len_too_big;
  logic                buf_we;
  logic [IDX_W-1:0]    rd_idx;
  logic [7:0]          rd_data;

  assign hs          = bus.in_valid & in_ready_q;
  assign len9        = {1'b0, len_q};
  assign len_m1      = len9 - 9'd1;
  assign sum_next    = sum_q + bus.in_data;
  assign len_too_big = len9 > MAX_LEN9;

  oc8051_loader_buf #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_idx_i  (IDX_W'(cnt_q)),
    .wr_data_i (bus.in_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN;
      len_q      <= '0;
      addr_q     <= '0;
      is_eof_q   <= 1'b0;
      err_q      <= ERR_NONE;
      cnt_q      <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rec_done_q <= 1'b0;
      rec_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      is_eof_q   <= is_eof_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rec_done_q <= rec_done_d;
      rec_err_q  <= rec_err_d;
      err_code_q <= err_code_d;
      eof_q      <= eof_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN:  if (hs) state_d = S_AH;
      S_AH:   if (hs) state_d = S_AL;
      S_AL:   if (hs) state_d = S_TYPE;
      S_TYPE: begin
        if (hs) begin
          if (len_too_big)                                      state_d = S_DROP;
          else if (bus.in_data == REC_DATA && len_q != 8'd0)    state_d = S_DATA;
          else if ((bus.in_data == REC_DATA || bus.in_data == REC_EOF) && len_q == 8'd0)
                                                                state_d = S_CSUM;
          else                                                  state_d = S_DROP;
        end
      end
      S_DATA: if (hs && cnt_q == len_m1) state_d = S_CSUM;
      // Drop consumes LEN data bytes plus the checksum byte.
      S_DROP: if (hs && cnt_q == len9) state_d = S_LEN;
      S_CSUM: begin
        if (hs) begin
          if (sum_next != 8'd0)  state_d = S_LEN;
          else if (is_eof_q)     state_d = S_EOF;
          else if (len_q == 8'd0) state_d = S_LEN;
          else                   state_d = S_COMMIT;
        end
      end
      S_COMMIT: if (cnt_q == len_m1) state_d = S_LEN;
      S_EOF:    state_d = S_EOF;
      default:  state_d = S_LEN;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    len_d      = len_q;
    addr_d     = addr_q;
    is_eof_d   = is_eof_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rec_done_d = 1'b0;
    rec_err_d  = 1'b0;
    err_code_d = ERR_NONE;
    eof_d      = eof_q;
    buf_we     = 1'b0;
    rd_idx     = '0;
    // in_ready is registered, so it is derived from where we are going.
    in_ready_d = !(state_d == S_COMMIT || state_d == S_EOF);

    // The LEN byte restarts the running checksum.
    if (hs) sum_d = (state_q == S_LEN) ? bus.in_data : sum_next;

    case (state_q)
      S_LEN: if (hs) len_d = bus.in_data;
      S_AH:  if (hs) addr_d[15:8] = bus.in_data;
      S_AL:  if (hs) addr_d[7:0]  = bus.in_data;
      S_TYPE: begin
        if (hs) begin
          cnt_d    = '0;
          is_eof_d = (bus.in_data == REC_EOF);
          err_d    = len_too_big ? ERR_LEN : ERR_TYPE;
        end
      end
      S_DATA: begin
        buf_we = hs;
        if (hs) cnt_d = cnt_q + 9'd1;
      end
      S_DROP: begin
        if (hs) begin
          if (cnt_q == len9) begin
            rec_err_d  = 1'b1;
            err_code_d = err_q;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          if (sum_next != 8'd0) begin
            rec_err_d  = 1'b1;
            err_code_d = ERR_CSUM;
          end else if (is_eof_q) begin
            eof_d      = 1'b1;
            rec_done_d = 1'b1;
          end else if (len_q == 8'd0) begin
            rec_done_d = 1'b1;
          end else begin
            // First write is launched here so it appears the cycle after CSUM.
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WID'(addr_q);
            wr_data_d = rd_data;
            cnt_d     = '0;
          end
        end
      end
      S_COMMIT: begin
        // cnt_q is the index of the byte currently on the write port.
        if (cnt_q == len_m1) begin
          rec_done_d = 1'b1;
        end else begin
          rd_idx    = IDX_W'(cnt_q + 9'd1);
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WID'(1);
          wr_data_d = rd_data;
          cnt_d     = cnt_q + 9'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rec_done = rec_done_q;
  assign bus.rec_err  = rec_err_q;
  assign bus.err_code = err_code_q;
  assign bus.eof      = eof_q;
  assign bus.busy     = (state_q != S_LEN);

endmodule

// File: tb/tb_oc8051_rom_loader.sv
// Bench for oc8051_rom_loader: directed record streams, a record-level
// reference model with a per-cycle compare, and literal per-scenario checks.
module tb_oc8051_rom_loader;

  localparam int MAX_LEN  = 16;
  localparam int ADDR_WID = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  oc8051_rom_loader_if #(.ADDR_WID(ADDR_WID)) bus ();

  oc8051_rom_loader #(.MAX_LEN(MAX_LEN), .ADDR_WID(ADDR_WID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic        done;
    logic        err;
    logic [1:0]  code;
  } ent_t;

  ent_t       sched[$];
  ent_t       cur   = '0;
  logic [7:0] rec[$];
  logic       eof_m = 1'b0;

  // Judge a complete record (LEN+5 bytes) and schedule what the
  // following cycles must show on the outputs.
  function automatic void model_record();
    int          len;
    logic [7:0]  typ;
    logic [15:0] base;
    logic [7:0]  sum;
    ent_t        e;
    len  = int'(rec[0]);
    typ  = rec[3];
    base = {rec[1], rec[2]};
    sum  = 8'h00;
    foreach (rec[i]) sum = sum + rec[i];
    e = '0;
    if (len > MAX_LEN) begin
      e.err = 1'b1; e.code = 2'd2; sched.push_back(e);
    end else if (!(typ == 8'h00 || (typ == 8'h01 && len == 0))) begin
      e.err = 1'b1; e.code = 2'd3; sched.push_back(e);
    end else if (sum != 8'h00) begin
      e.err = 1'b1; e.code = 2'd1; sched.push_back(e);
    end else begin
      if (typ == 8'h01) eof_m = 1'b1;
      for (int i = 0; i < len; i++) begin
        e = '0; e.wr = 1'b1; e.a = base + 16'(i); e.d = rec[4+i];
        sched.push_back(e);
      end
      e = '0; e.done = 1'b1; sched.push_back(e);
    end
    rec.delete();
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      sched.delete(); rec.delete(); eof_m = 1'b0; cur = '0;
    end else begin
      if (bus.in_valid === 1'b1 && !cur.wr && !eof_m) begin
        rec.push_back(bus.in_data);
        if (rec.size() >= 4 && rec.size() == int'(rec[0]) + 5) model_record();
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = '0;
    end
  end

  // ---------------- compare + event log ----------------
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          done_cnt, err_cnt, done_cyc, err_cyc;
  logic [1:0]  err_code_l;

  initial forever begin
    @(negedge clk);
    chk("in_ready", bus.in_ready, !cur.wr && !eof_m);
    chk("wr_en",    bus.wr_en,    cur.wr);
    chk("rec_done", bus.rec_done, cur.done);
    chk("rec_err",  bus.rec_err,  cur.err);
    chk("eof",      bus.eof,      eof_m);
    chk("busy",     bus.busy,     rec.size() != 0 || cur.wr || eof_m);
    if (cur.wr) begin
      chk("wr_addr", bus.wr_addr, cur.a);
      chk("wr_data", bus.wr_data, cur.d);
    end
    if (cur.err) chk("err_code", bus.err_code, cur.code);
    if (bus.wr_en === 1'b1) begin
      wa.push_back(bus.wr_addr); wd.push_back(bus.wr_data); wc.push_back(cyc);
    end
    if (bus.rec_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (bus.rec_err === 1'b1) begin err_cnt++; err_cyc = cyc; err_code_l = bus.err_code; end
  end

  function automatic logic [31:0] wa_at(input int k);
    return (k < wa.size()) ? {16'h0, wa[k]} : 'x;
  endfunction
  function automatic logic [31:0] wd_at(input int k);
    return (k < wd.size()) ? {24'h0, wd[k]} : 'x;
  endfunction
  function automatic int wc_at(input int k);
    return (k < wc.size()) ? wc[k] : -1;
  endfunction

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; err_code_l = 2'd0;
  endtask

  // ---------------- drivers ----------------
  logic [7:0] txq[$];
  int         last_hs;

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin ok = 1'b1; last_hs = cyc; end
      @(posedge clk); #1;
      n++;
    end
    if (!ok) chk("handshake", {31'b0, ok}, 1);
  endtask

  task automatic send_txq(input int maxgap);
    foreach (txq[i]) send_byte(txq[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    bus.in_valid = 1'b0;
    txq.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_s1(input string tag, input int t);
    chk({tag, "_nwr"},   wa.size(), 3);
    chk({tag, "_a0"},    wa_at(0), 32'h0024);
    chk({tag, "_d0"},    wd_at(0), 32'h75);
    chk({tag, "_a1"},    wa_at(1), 32'h0025);
    chk({tag, "_d1"},    wd_at(1), 32'hA8);
    chk({tag, "_a2"},    wa_at(2), 32'h0026);
    chk({tag, "_d2"},    wd_at(2), 32'h8A);
    chk({tag, "_c0"},    wc_at(0), t + 1);
    chk({tag, "_c2"},    wc_at(2), t + 3);
    chk({tag, "_dcyc"},  done_cyc, t + 4);
    chk({tag, "_ndone"}, done_cnt, 1);
    chk({tag, "_nerr"},  err_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wr_en",    bus.wr_en,    0);
    chk("rst_wr_addr",  bus.wr_addr,  0);
    chk("rst_wr_data",  bus.wr_data,  0);
    chk("rst_done",     bus.rec_done, 0);
    chk("rst_err",      bus.rec_err,  0);
    chk("rst_code",     bus.err_code, 0);
    chk("rst_eof",      bus.eof,      0);
    chk("rst_busy",     bus.busy,     0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Three-byte data record at 0x0024
    clear_logs();
    txq = {8'h03, 8'h00, 8'h24, 8'h00, 8'h75, 8'hA8, 8'h8A, 8'h32};
    send_txq(0); t = last_hs; settle(6);
    check_s1("s1", t);

    // Same record with a wrong checksum
    clear_logs();
    txq = {8'h03, 8'h00, 8'h24, 8'h00, 8'h75, 8'hA8, 8'h8A, 8'h33};
    send_txq(0); t = last_hs; settle(6);
    chk("csum_nerr", err_cnt, 1);
    chk("csum_code", err_code_l, 1);
    chk("csum_ecyc", err_cyc, t + 1);
    chk("csum_nwr",  wa.size(), 0);
    chk("csum_done", done_cnt, 0);

    // Next record is accepted normally
    clear_logs();
    txq = {8'h03, 8'h00, 8'h24, 8'h00, 8'h75, 8'hA8, 8'h8A, 8'h32};
    send_txq(0); t = last_hs; settle(6);
    check_s1("s1b", t);

    // Address wrap FFFF -> 0000
    clear_logs();
    txq = {8'h02, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'hCD};
    send_txq(0); settle(6);
    chk("wrap_nwr", wa.size(), 2);
    chk("wrap_a0",  wa_at(0), 32'hFFFF);
    chk("wrap_d0",  wd_at(0), 32'h11);
    chk("wrap_a1",  wa_at(1), 32'h0000);
    chk("wrap_d1",  wd_at(1), 32'h22);
    chk("wrap_done", done_cnt, 1);

    // Unsupported type 05
    clear_logs();
    txq = {8'h00, 8'h00, 8'h10, 8'h05, 8'hEB};
    send_txq(0); t = last_hs; settle(4);
    chk("type_nerr", err_cnt, 1);
    chk("type_code", err_code_l, 3);
    chk("type_ecyc", err_cyc, t + 1);
    chk("type_nwr",  wa.size(), 0);

    // First record again with random valid gaps
    clear_logs();
    txq = {8'h03, 8'h00, 8'h24, 8'h00, 8'h75, 8'hA8, 8'h8A, 8'h32};
    send_txq(3); t = last_hs; settle(6);
    check_s1("gaps", t);

    // LEN 0x11 exceeds the buffer: 22 bytes in total are swallowed
    clear_logs();
    txq = {8'h11, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 18; i++) txq.push_back(8'(i * 7 + 3));
    send_txq(0); t = last_hs; settle(4);
    chk("len_nerr", err_cnt, 1);
    chk("len_code", err_code_l, 2);
    chk("len_ecyc", err_cyc, t + 1);
    chk("len_nwr",  wa.size(), 0);
    chk("len_done", done_cnt, 0);

    // End-of-file record
    clear_logs();
    txq = {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
    send_txq(0); t = last_hs; settle(6);
    chk("eof_done",  done_cnt, 1);
    chk("eof_dcyc",  done_cyc, t + 1);
    chk("eof_flag",  bus.eof, 1);
    chk("eof_ready", bus.in_ready, 0);

    // Reset clears the sticky EOF
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_eof",   bus.eof, 0);
    chk("rst2_ready", bus.in_ready, 1);
    chk("rst2_busy",  bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset in the middle of a commit
    clear_logs();
    txq = {8'h03, 8'h00, 8'h24, 8'h00, 8'h75, 8'hA8, 8'h8A, 8'h32};
    send_txq(0);
    @(negedge clk);
    n = 1;
    while (bus.wr_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("rc_first_wr", bus.wr_en, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rc_wr_en",  bus.wr_en, 0);
    chk("rc_ready",  bus.in_ready, 1);
    chk("rc_done",   bus.rec_done, 0);
    chk("rc_waddr",  bus.wr_addr, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    settle(4);
    chk("rc_nwr",   wa.size(), 1);
    chk("rc_ndone", done_cnt, 0);

    // Fresh record after the aborted commit
    clear_logs();
    txq = {8'h02, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'hCD};
    send_txq(0); settle(6);
    chk("post_nwr",  wa.size(), 2);
    chk("post_a0",   wa_at(0), 32'hFFFF);
    chk("post_d1",   wd_at(1), 32'h22);
    chk("post_done", done_cnt, 1);

    settle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
